// File: rtl/fifo_frame_reader.sv
// Drains a programmed job of num_frames x frame_len words from an FWFT FIFO and
// re-times them through a 2-entry buffer onto a valid/ready stream with frame tags.
module fifo_frame_reader #(
    parameter int DATA_WIDTH   = 40,
    parameter int FRAME_LEN_W  = 12,
    parameter int NUM_FRAMES_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [FRAME_LEN_W-1:0]  frame_len,
    input  logic [NUM_FRAMES_W-1:0] num_frames,
    output logic                    busy,
    output logic                    done,
    input  logic [DATA_WIDTH-1:0]   fifo_dout,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_vld,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [NUM_FRAMES_W-1:0] out_frame_idx
);

    localparam int TOT_W = FRAME_LEN_W + NUM_FRAMES_W;
    localparam logic [FRAME_LEN_W-1:0]  LEN_ONE   = FRAME_LEN_W'(1);
    localparam logic [NUM_FRAMES_W-1:0] FRAME_ONE = NUM_FRAMES_W'(1);
    localparam logic [TOT_W-1:0]        TOT_ONE   = TOT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [FRAME_LEN_W-1:0]  len_r;
    logic [FRAME_LEN_W-1:0]  beat_cnt;
    logic [NUM_FRAMES_W-1:0] frame_cnt;
    logic [TOT_W-1:0]        total;
    logic [TOT_W-1:0]        pop_cnt;

    logic [1:0][DATA_WIDTH-1:0]   buf_data;
    logic [1:0]                   buf_last;
    logic [1:0][NUM_FRAMES_W-1:0] buf_idx;
    logic [1:0]                   count;

    logic pop, xfer, pop_last, widx;

    // Pop decision uses only registered state plus the FIFO flag, so out_ready
    // never reaches the FIFO combinationally.
    assign pop      = (state == RUN) && !fifo_empty && (count != 2'd2) && (pop_cnt != total);
    assign xfer     = out_valid && out_ready;
    assign pop_last = (beat_cnt == len_r - LEN_ONE);
    // On a simultaneous pop and transfer the only occupied entry leaves, so the
    // new word lands in entry 0.
    assign widx     = xfer ? 1'b0 : count[0];

    assign fifo_rd_vld   = pop;
    assign out_valid     = (count != 2'd0);
    assign out_data      = buf_data[0];
    assign out_last      = buf_last[0];
    assign out_frame_idx = buf_idx[0];
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (frame_len == '0 || num_frames == '0) ? DONE : RUN;
            RUN:  if (pop_cnt == total && count == 2'd0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_r     <= '0;
            total     <= '0;
            pop_cnt   <= '0;
            beat_cnt  <= '0;
            frame_cnt <= '0;
            buf_data  <= '0;
            buf_last  <= '0;
            buf_idx   <= '0;
            count     <= '0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && start) begin
                len_r     <= frame_len;
                total     <= TOT_W'(frame_len) * TOT_W'(num_frames);
                pop_cnt   <= '0;
                beat_cnt  <= '0;
                frame_cnt <= '0;
            end

            // Tags are resolved at pop time and travel with the word.
            if (pop) begin
                pop_cnt <= pop_cnt + TOT_ONE;
                if (pop_last) begin
                    beat_cnt  <= '0;
                    frame_cnt <= frame_cnt + FRAME_ONE;
                end else begin
                    beat_cnt <= beat_cnt + LEN_ONE;
                end
            end

            if (xfer && !pop) begin
                buf_data[0] <= buf_data[1];
                buf_last[0] <= buf_last[1];
                buf_idx[0]  <= buf_idx[1];
            end
            if (pop) begin
                buf_data[widx] <= fifo_dout;
                buf_last[widx] <= pop_last;
                buf_idx[widx]  <= frame_cnt;
            end

            count <= count + {1'b0, pop} - {1'b0, xfer};
        end
    end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader: an FWFT FIFO model feeds the DUT and a scoreboard
// of expected beats (data, last, frame index) is checked at every transfer.
module tb_fifo_frame_reader;

    localparam int DW = 40;
    localparam int FW = 12;
    localparam int NW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [FW-1:0] frame_len;
    logic [NW-1:0] num_frames;
    logic          busy, done;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty, fifo_rd_vld;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready, out_last;
    logic [NW-1:0] out_frame_idx;

    always #5 clk = ~clk;

    fifo_frame_reader #(.DATA_WIDTH(DW), .FRAME_LEN_W(FW), .NUM_FRAMES_W(NW)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .num_frames(num_frames),
        .busy(busy), .done(done), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_vld(fifo_rd_vld), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .out_frame_idx(out_frame_idx)
    );

    // FWFT FIFO model
    logic [DW-1:0] mem [256];
    logic [7:0]    wr_ptr, rd_ptr;
    logic          flush_req;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_dout  = mem[rd_ptr];

    always @(posedge clk) begin
        if (flush_req) rd_ptr <= wr_ptr;
        else if (fifo_rd_vld && !fifo_empty) rd_ptr <= rd_ptr + 8'd1;
    end

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic [NW-1:0] f;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = DW'(base + i);
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    task automatic expect_job(input int len, input int nf, input int base);
        exp_t e;
        for (int i = 0; i < len * nf; i++) begin
            e.d = DW'(base + i);
            e.l = ((i % len) == len - 1);
            e.f = NW'(i / len);
            expq.push_back(e);
        end
    endtask

    task automatic flush();
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
    endtask

    task automatic kick(input int len, input int nf);
        @(negedge clk);
        frame_len  = FW'(len);
        num_frames = NW'(nf);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs cycle by cycle from the negedge after start, checking every beat
    // against the scoreboard plus occupancy, stall-hold and busy/done behaviour.
    task automatic drain(input int max_cyc, input bit rand_rdy, input int gap,
                         input int nfeed, input int feed_base, input int pulse_at,
                         input int abort_after, output int pops, output int xfers);
        int            occ = 0;
        int            fed = 0;
        bit            stall = 0;
        bit            saw_done = 0;
        bit            aborted = 0;
        logic [DW-1:0] hd;
        logic          hl;
        logic [NW-1:0] hf;
        exp_t          e;
        pops = 0;
        xfers = 0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            if (gap > 0 && fed < nfeed && (cyc % gap) == 0) begin
                load(1, feed_base + fed);
                fed++;
            end
            if (cyc == pulse_at) begin
                start = 1'b1; frame_len = FW'(1); num_frames = NW'(1);
            end else begin
                start = 1'b0;
            end
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            n_cmp++;
            if (busy !== 1'b1) begin
                n_bad++; $display("FAIL busy_during_job cyc=%0d got %b want 1", cyc, busy);
            end
            n_cmp++;
            if (out_valid !== (occ != 0)) begin
                n_bad++; $display("FAIL out_valid cyc=%0d got %b want %b", cyc, out_valid, occ != 0);
            end
            if (fifo_rd_vld) begin
                n_cmp++;
                if (occ >= 2 || fifo_empty) begin
                    n_bad++; $display("FAIL pop_blocked cyc=%0d got rd_vld=1 occ=%0d empty=%b want no pop", cyc, occ, fifo_empty);
                end
            end
            if (stall) begin
                n_cmp++;
                if (out_data !== hd || out_last !== hl || out_frame_idx !== hf) begin
                    n_bad++; $display("FAIL stall_hold cyc=%0d got %h/%b/%0d want %h/%b/%0d", cyc, out_data, out_last, out_frame_idx, hd, hl, hf);
                end
            end
            if (done) begin
                saw_done = 1;
                n_cmp++;
                if (expq.size() != 0 || occ != 0) begin
                    n_bad++; $display("FAIL done_early cyc=%0d got pending=%0d occ=%0d want 0/0", cyc, expq.size(), occ);
                end
                break;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++; $display("FAIL extra_beat cyc=%0d got data=%h want none", cyc, out_data);
                end else begin
                    e = expq.pop_front();
                    if (out_data !== e.d || out_last !== e.l || out_frame_idx !== e.f) begin
                        n_bad++; $display("FAIL beat cyc=%0d got %h/%b/%0d want %h/%b/%0d", cyc, out_data, out_last, out_frame_idx, e.d, e.l, e.f);
                    end
                end
                xfers++; occ--;
            end
            if (fifo_rd_vld) begin
                pops++; occ++;
            end
            stall = out_valid && !out_ready;
            hd = out_data; hl = out_last; hf = out_frame_idx;
            if (abort_after > 0 && xfers == abort_after) begin
                aborted = 1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!aborted) begin
            n_cmp++;
            if (!saw_done) begin
                n_bad++; $display("FAIL done_timeout got no done within %0d cycles want done", max_cyc);
            end else begin
                @(negedge clk); #1;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    n_bad++; $display("FAIL done_pulse got done=%b busy=%b want 0/0", done, busy);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || fifo_rd_vld !== 1'b0) begin
            n_bad++; $display("FAIL reset_ctrl got busy=%b done=%b rd=%b want 0/0/0", busy, done, fifo_rd_vld);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || out_frame_idx !== '0) begin
            n_bad++; $display("FAIL reset_stream got v=%b l=%b d=%h f=%0d want zeros", out_valid, out_last, out_data, out_frame_idx);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int p, x;
        logic [7:0] rd0;
        load(12, 0);
        expect_job(4, 3, 0);
        rd0 = rd_ptr;
        kick(4, 3);
        drain(200, 0, 0, 0, 0, -1, 0, p, x);
        n_cmp++;
        if (p != 12 || x != 12 || (rd_ptr - rd0) != 8'd12) begin
            n_bad++; $display("FAIL basic_counts got pops=%0d xfers=%0d fifo_pops=%0d want 12", p, x, rd_ptr - rd0);
        end
    endtask

    task automatic test_backpressure();
        int p, x;
        load(12, 100);
        expect_job(4, 3, 100);
        kick(4, 3);
        drain(600, 1, 0, 0, 0, -1, 0, p, x);
        n_cmp++;
        if (p != 12 || x != 12) begin
            n_bad++; $display("FAIL bp_counts got pops=%0d xfers=%0d want 12/12", p, x);
        end
    endtask

    task automatic test_trickle();
        int p, x;
        expect_job(2, 2, 200);
        kick(2, 2);
        drain(200, 0, 3, 4, 200, -1, 0, p, x);
        n_cmp++;
        if (p != 4 || x != 4) begin
            n_bad++; $display("FAIL trickle_counts got pops=%0d xfers=%0d want 4/4", p, x);
        end
    endtask

    task automatic test_zero_job();
        int p, x;
        load(3, 250);
        kick(0, 3);
        drain(5, 0, 0, 0, 0, -1, 0, p, x);
        kick(5, 0);
        drain(5, 0, 0, 0, 0, -1, 0, p, x);
        n_cmp++;
        if (p != 0 || fifo_empty !== 1'b0) begin
            n_bad++; $display("FAIL zero_job got pops=%0d empty=%b want 0/0", p, fifo_empty);
        end
        flush();
    endtask

    task automatic test_surplus();
        int p, x;
        load(20, 400);
        expect_job(3, 2, 400);
        kick(3, 2);
        drain(200, 0, 0, 0, 0, 2, 0, p, x);
        n_cmp++;
        if (p != 6 || (wr_ptr - rd_ptr) != 8'd14 || fifo_empty !== 1'b0) begin
            n_bad++; $display("FAIL surplus got pops=%0d left=%0d empty=%b want 6/14/0", p, wr_ptr - rd_ptr, fifo_empty);
        end
        flush();
    endtask

    task automatic test_reset_mid_job();
        int p, x;
        load(12, 500);
        expect_job(4, 3, 500);
        kick(4, 3);
        drain(200, 0, 0, 0, 0, -1, 5, p, x);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || fifo_rd_vld !== 1'b0 || out_valid !== 1'b0 ||
            out_last !== 1'b0 || out_data !== '0 || out_frame_idx !== '0) begin
            n_bad++; $display("FAIL mid_reset got busy=%b done=%b rd=%b v=%b l=%b d=%h f=%0d want zeros",
                              busy, done, fifo_rd_vld, out_valid, out_last, out_data, out_frame_idx);
        end
        rst = 1'b0;
        expq.delete();
        flush();
        load(6, 600);
        expect_job(3, 2, 600);
        kick(3, 2);
        drain(200, 0, 0, 0, 0, -1, 0, p, x);
        n_cmp++;
        if (p != 6 || x != 6) begin
            n_bad++; $display("FAIL rerun_counts got pops=%0d xfers=%0d want 6/6", p, x);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; frame_len = '0; num_frames = '0; out_ready = 1'b0;
        wr_ptr = 8'd0; flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_trickle();
        test_zero_job();
        test_surplus();
        test_reset_mid_job();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
